// File: rtl/turn_controller_if.sv
// Bundle between the turn controller and the game harness: raw buttons, switches and
// health in, latched actions and game status out.
interface turn_controller_if;
  logic       confirm1, confirm2;
  logic [2:0] sw1, sw2;
  logic [1:0] health1, health2;
  logic [2:0] action1, action2;
  logic       actionEnable;
  logic       isGameOver;
  logic [1:0] winner;
  logic [7:0] turnCount;

  modport master (
    output confirm1, confirm2, sw1, sw2, health1, health2,
    input  action1, action2, actionEnable, isGameOver, winner, turnCount
  );

  modport slave (
    input  confirm1, confirm2, sw1, sw2, health1, health2,
    output action1, action2, actionEnable, isGameOver, winner, turnCount
  );
endinterface

// File: rtl/turn_controller.sv
// Two-player turn sequencer: debounced confirm buttons latch each player's action in turn,
// then a fixed-width enable strobe applies both and health decides whether the game ends.

module tc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_a_q, sync_b_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt counts consecutive synced samples that disagree with the accepted level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_b_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_b_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q <= 1'b0;
      sync_b_q <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_a_q <= raw;
      sync_b_q <= sync_a_q;
      level_q  <= level_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

module turn_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ENABLE_CYCLES   = 2,
  parameter int TURN_TIMEOUT    = 200
) (
  input logic               clk,
  input logic               reset,
  turn_controller_if.slave  bus
);
  localparam int CNT_MAX = (TURN_TIMEOUT > ENABLE_CYCLES) ? TURN_TIMEOUT : ENABLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0] ACT_AWAIT = 3'b010;

  typedef enum logic [2:0] {WAIT_P1, WAIT_P2, APPLY, SETTLE, OVER} state_e;

  logic [1:0]       press;
  logic [1:0][2:0]  sw_a_q, sw_b_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       action1_q, action1_d, action2_q, action2_d;
  logic             enable_q, enable_d;
  logic             over_q, over_d;
  logic [1:0]       winner_q, winner_d;
  logic [7:0]       turn_q, turn_d;

  tc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   ({bus.confirm2, bus.confirm1}),
    .press (press)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    action1_d = action1_q;
    action2_d = action2_q;
    enable_d  = enable_q;
    over_d    = over_q;
    winner_d  = winner_q;
    turn_d    = turn_q;
    case (state_q)
      // a press wins over a simultaneous timeout; presses from the other player just drop
      WAIT_P1: begin
        if (press[0] || cnt_q == CNT_W'(TURN_TIMEOUT - 1)) begin
          action1_d = press[0] ? sw_b_q[0] : ACT_AWAIT;
          state_d   = WAIT_P2;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_P2: begin
        if (press[1] || cnt_q == CNT_W'(TURN_TIMEOUT - 1)) begin
          action2_d = press[1] ? sw_b_q[1] : ACT_AWAIT;
          state_d   = APPLY;
          enable_d  = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      APPLY: begin
        if (cnt_q == CNT_W'(ENABLE_CYCLES - 1)) begin
          enable_d = 1'b0;
          state_d  = SETTLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        turn_d = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
        if (bus.health1 == 2'b00 || bus.health2 == 2'b00) begin
          state_d  = OVER;
          over_d   = 1'b1;
          winner_d = {bus.health1 == 2'b00, bus.health2 == 2'b00};
        end else begin
          state_d = WAIT_P1;
          cnt_d   = '0;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = WAIT_P1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_a_q    <= '0;
      sw_b_q    <= '0;
      state_q   <= WAIT_P1;
      cnt_q     <= '0;
      action1_q <= ACT_AWAIT;
      action2_q <= ACT_AWAIT;
      enable_q  <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 2'b00;
      turn_q    <= 8'd0;
    end else begin
      sw_a_q    <= {bus.sw2, bus.sw1};
      sw_b_q    <= sw_a_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      action1_q <= action1_d;
      action2_q <= action2_d;
      enable_q  <= enable_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      turn_q    <= turn_d;
    end
  end

  assign bus.action1      = action1_q;
  assign bus.action2      = action2_q;
  assign bus.actionEnable = enable_q;
  assign bus.isGameOver   = over_q;
  assign bus.winner       = winner_q;
  assign bus.turnCount    = turn_q;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: a per-edge behavioural model of the turn rules is
// compared every cycle, plus hand-computed checks on latency, timeout, game over and reset.
module tb_turn_controller;
  localparam int DB = 4;
  localparam int EN = 2;
  localparam int TO = 200;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic armed = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   en_hi  = 0;

  turn_controller_if bus();

  turn_controller #(.DEBOUNCE_CYCLES(DB), .ENABLE_CYCLES(EN), .TURN_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---- behavioural model: phase 0 wait p1, 1 wait p2, 2 strobe, 3 settle, 4 game over
  logic       hc1 [0:DB+1];
  logic       hc2 [0:DB+1];
  logic [2:0] hs1 [0:2];
  logic [2:0] hs2 [0:2];
  logic       lvl1, lvl2, ev1, ev2, use1, use2, diff1, diff2;
  int         phase, waited, en_left, m_tc;
  logic [2:0] m_a1, m_a2;
  logic       m_en, m_over;
  logic [1:0] m_win;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k <= DB + 1; k++) begin hc1[k] = 1'b0; hc2[k] = 1'b0; end
      for (int k = 0; k <= 2; k++) begin hs1[k] = 3'b000; hs2[k] = 3'b000; end
      lvl1 = 1'b0; lvl2 = 1'b0; ev1 = 1'b0; ev2 = 1'b0;
      phase = 0; waited = 0; en_left = 0; m_tc = 0;
      m_a1 = 3'b010; m_a2 = 3'b010; m_en = 1'b0; m_over = 1'b0; m_win = 2'b00;
    end else begin
      // raw inputs reach the logic two samples late
      for (int k = DB + 1; k > 0; k--) begin hc1[k] = hc1[k-1]; hc2[k] = hc2[k-1]; end
      for (int k = 2; k > 0; k--) begin hs1[k] = hs1[k-1]; hs2[k] = hs2[k-1]; end
      hc1[0] = bus.confirm1; hc2[0] = bus.confirm2; hs1[0] = bus.sw1; hs2[0] = bus.sw2;
      use1 = ev1; use2 = ev2;
      if (phase == 0 || phase == 1) begin
        waited++;
        if (phase == 0 && (use1 || waited == TO)) begin
          m_a1 = use1 ? hs1[2] : 3'b010; phase = 1; waited = 0;
        end else if (phase == 1 && (use2 || waited == TO)) begin
          m_a2 = use2 ? hs2[2] : 3'b010; phase = 2; waited = 0; m_en = 1'b1; en_left = EN;
        end
      end else if (phase == 2) begin
        en_left--;
        if (en_left == 0) begin m_en = 1'b0; phase = 3; end
      end else if (phase == 3) begin
        if (m_tc < 255) m_tc++;
        if (bus.health1 == 2'b00 || bus.health2 == 2'b00) begin
          phase = 4; m_over = 1'b1;
          if (bus.health1 == 2'b00 && bus.health2 == 2'b00) m_win = 2'b11;
          else if (bus.health2 == 2'b00)                    m_win = 2'b01;
          else                                              m_win = 2'b10;
        end else begin
          phase = 0; waited = 0;
        end
      end
      // accepted level flips once the last DB delayed samples all disagree with it
      diff1 = 1'b1; diff2 = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (hc1[k] == lvl1) diff1 = 1'b0;
        if (hc2[k] == lvl2) diff2 = 1'b0;
      end
      ev1 = diff1 && !lvl1; ev2 = diff2 && !lvl2;
      if (diff1) lvl1 = ~lvl1;
      if (diff2) lvl2 = ~lvl2;
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.actionEnable) en_hi++;
    if (armed)
      chk("cycle_outputs",
          {14'd0, bus.action1, bus.action2, bus.actionEnable, bus.isGameOver, bus.winner, bus.turnCount},
          {14'd0, m_a1, m_a2, m_en, m_over, m_win, m_tc[7:0]});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  task automatic press(input int who, input logic [2:0] s);
    @(negedge clk);
    if (who == 1) begin bus.sw1 = s; bus.confirm1 = 1'b1; end
    else          begin bus.sw2 = s; bus.confirm2 = 1'b1; end
    repeat (8) @(negedge clk);
    bus.confirm1 = 1'b0; bus.confirm2 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  int k, e0;

  initial begin
    bus.confirm1 = 1'b0; bus.confirm2 = 1'b0;
    bus.sw1 = 3'b000; bus.sw2 = 3'b000;
    bus.health1 = 2'b11; bus.health2 = 2'b11;
    @(negedge clk); armed = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst_action1", bus.action1, 3'b010);
    chk("rst_action2", bus.action2, 3'b010);
    chk("rst_enable", bus.actionEnable, 0);
    chk("rst_over", bus.isGameOver, 0);
    chk("rst_winner", bus.winner, 0);
    chk("rst_turncount", bus.turnCount, 0);

    // normal turn; press reaches the FSM one edge after the 2+DB event
    @(negedge clk); bus.sw1 = 3'b110; bus.confirm1 = 1'b1;
    repeat (6) @(negedge clk);
    chk("p1_latency_early", bus.action1, 3'b010);
    @(negedge clk);
    chk("p1_latency_exact", bus.action1, 3'b110);
    repeat (3) @(negedge clk); bus.confirm1 = 1'b0;
    repeat (8) @(negedge clk);
    e0 = en_hi;
    press(2, 3'b000);
    chk("t1_action1", bus.action1, 3'b110);
    chk("t1_action2", bus.action2, 3'b000);
    chk("t1_enable_cycles", en_hi - e0, 2);
    chk("t1_turncount", bus.turnCount, 1);

    // 3-sample glitch alone
    @(negedge clk); bus.sw1 = 3'b100; bus.confirm1 = 1'b1;
    repeat (3) @(negedge clk); bus.confirm1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_no_event", bus.action1, 3'b110);

    // bouncing press, then player 2 times out
    for (int w = 1; w <= 3; w++) begin
      bus.confirm1 = 1'b1; repeat (w) @(negedge clk);
      bus.confirm1 = 1'b0; repeat (2) @(negedge clk);
    end
    bus.confirm1 = 1'b1;
    repeat (6) @(negedge clk);
    chk("bounce_before_event", bus.action1, 3'b110);
    @(negedge clk);
    chk("bounce_latency", bus.action1, 3'b100);
    k = 0;
    while (!bus.actionEnable && k < 400) begin
      @(negedge clk); k++;
      if (k == 3) bus.confirm1 = 1'b0;
    end
    chk("timeout_cycles", k, TO);
    chk("timeout_action2", bus.action2, 3'b010);
    repeat (4) @(negedge clk);
    chk("timeout_turncount", bus.turnCount, 2);

    // player 2 pressing out of order
    press(2, 3'b111);
    chk("ooo_action2_kept", bus.action2, 3'b010);
    chk("ooo_action1_kept", bus.action1, 3'b100);
    press(1, 3'b011);
    chk("ooo_p1_ok", bus.action1, 3'b011);
    press(2, 3'b101);
    chk("ooo_p2_ok", bus.action2, 3'b101);
    chk("ooo_turncount", bus.turnCount, 3);

    // health dip outside settle is ignored
    @(negedge clk); bus.health1 = 2'b00;
    press(1, 3'b001);
    bus.health1 = 2'b11;
    press(2, 3'b110);
    chk("health_ignored", bus.isGameOver, 0);
    chk("health_turncount", bus.turnCount, 4);

    // player 2 dies
    bus.health2 = 2'b00;
    press(1, 3'b000);
    press(2, 3'b000);
    chk("over_flag", bus.isGameOver, 1);
    chk("over_winner_p1", bus.winner, 2'b01);
    chk("over_turncount", bus.turnCount, 5);
    e0 = en_hi;
    press(1, 3'b111);
    press(2, 3'b111);
    chk("over_no_enable", en_hi - e0, 0);
    chk("over_winner_held", bus.winner, 2'b01);
    chk("over_action1_held", bus.action1, 3'b000);

    // both die -> draw
    do_reset();
    chk("rst2_over", bus.isGameOver, 0);
    chk("rst2_winner", bus.winner, 0);
    chk("rst2_turncount", bus.turnCount, 0);
    bus.health1 = 2'b00;
    press(1, 3'b001);
    press(2, 3'b010);
    chk("draw_winner", bus.winner, 2'b11);
    chk("draw_over", bus.isGameOver, 1);

    // reset in the first strobe cycle
    do_reset();
    bus.health1 = 2'b11; bus.health2 = 2'b11;
    press(1, 3'b111);
    @(negedge clk); bus.sw2 = 3'b011; bus.confirm2 = 1'b1;
    k = 0;
    while (!bus.actionEnable && k < 20) begin @(negedge clk); k++; end
    chk("apply_reached", bus.actionEnable, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_apply_enable", bus.actionEnable, 0);
    chk("rst_apply_action1", bus.action1, 3'b010);
    chk("rst_apply_action2", bus.action2, 3'b010);
    chk("rst_apply_turncount", bus.turnCount, 0);
    reset = 1'b0; bus.confirm2 = 1'b0;
    repeat (10) @(negedge clk);

    // turn counter saturation
    for (int t = 0; t < 256; t++) begin
      press(1, 3'(t));
      press(2, 3'(t + 3));
    end
    chk("sat_turncount", bus.turnCount, 255);
    chk("sat_not_over", bus.isGameOver, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a new confirm-button level.
REQ-002 Parameter ENABLE_CYCLES, default 2: number of cycles actionEnable is held high per turn.
REQ-003 Parameter TURN_TIMEOUT, default 200: cycles a player may take to confirm before the action is forced.
REQ-004 clk  in  1  the single clock; all logic is rising-edge clocked.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 confirm1, confirm2  in  1 each  raw, asynchronous, bouncing confirm buttons for player 1 and player 2.
REQ-007 sw1, sw2  in  3 each  raw action switches for each player; these use the player action encoding (kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111).
REQ-008 health1, health2  in  2 each  current health from the two player blocks.
REQ-009 action1, action2  out  3 each  latched actions presented to both player blocks.
REQ-010 actionEnable  out  1  turn strobe consumed by the player blocks.
REQ-011 isGameOver  out  1  high once the game is decided.
REQ-012 winner  out  2  game result: 00 none, 01 player 1, 10 player 2, 11 draw.
REQ-013 turnCount  out  8  number of completed turns, saturating.

Function
REQ-014 Each confirm input SHALL pass through a 2-flop synchronizer followed by a debouncer; a press event SHALL be a single-cycle 0->1 transition of the debounced level.
REQ-015 Press latency SHALL be exactly 2+DEBOUNCE_CYCLES cycles from a clean raw rising edge; a raw pulse shorter than DEBOUNCE_CYCLES samples SHALL produce no event.
REQ-016 The FSM SHALL have the states WAIT_P1, WAIT_P2, APPLY, SETTLE and OVER; reset SHALL enter WAIT_P1.
REQ-017 In WAIT_P1, a player-1 press event SHALL latch the synchronized sw1 into action1 and move the FSM to WAIT_P2; player-2 events SHALL be discarded, not queued.
REQ-018 In WAIT_P2, a player-2 press event SHALL latch sw2 into action2 and move the FSM to APPLY; player-1 events SHALL be discarded.
REQ-019 A cycle counter SHALL clear on entry to each wait state; if it reaches TURN_TIMEOUT with no event, the FSM SHALL latch await (010) for that player and advance exactly as if the player had pressed.
REQ-020 In APPLY, actionEnable SHALL be high for exactly ENABLE_CYCLES consecutive cycles, with action1 and action2 stable for that whole window; the FSM SHALL then enter SETTLE with actionEnable low.
REQ-021 actionEnable SHALL be low in every state except APPLY, so that each turn produces a separate low-to-high edge.
REQ-022 SETTLE SHALL last one cycle, during which turnCount SHALL increment; turnCount saturates at 255.
REQ-023 At the end of SETTLE, health1 and health2 SHALL be sampled and the FSM SHALL go to OVER if either is 00, otherwise to WAIT_P1.
REQ-024 On entering OVER, winner SHALL be set as follows: 01 if only health2==00, 10 if only health1==00, 11 if both are 00.
REQ-025 OVER SHALL hold isGameOver=1, actionEnable=0 and winner stable until reset; all press events SHALL be ignored in OVER.
REQ-026 Health values SHALL be read only in SETTLE; changes in health during other states SHALL have no effect.

Reset
REQ-027 On reset, the outputs SHALL take these values: action1=action2=010, actionEnable=0, isGameOver=0, winner=00, turnCount=0.
REQ-028 Reset SHALL also clear the synchronizers, debouncers and the timeout counter, and place the FSM in WAIT_P1.
REQ-029 Reset asserted in any state, including mid-APPLY, SHALL force actionEnable low on the next clock edge.

Verification
REQ-030 Normal turn: sw1=110, clean confirm1, then sw2=000, clean confirm2 -> action1=110 and action2=000; actionEnable high for 2 cycles; turnCount 0->1; FSM returns to WAIT_P1.
REQ-031 Bounce: confirm1 toggling with high pulses of 1-3 cycles, then stable high -> exactly one event, occurring 6 cycles after the stable edge; a 3-cycle glitch alone -> no event.
REQ-032 Timeout: player 1 presses, player 2 is idle for 200 cycles -> action2=010 and an APPLY window follows.
REQ-033 Out-of-order press: confirm2 pressed in WAIT_P1 -> ignored, FSM stays in WAIT_P1; a later player-1 press is handled normally.
REQ-034 Game over: health2 driven to 00 before SETTLE -> isGameOver=1 and winner=01; both healths 00 -> winner=11; further presses produce no actionEnable.
REQ-035 Reset: reset pulsed in the first APPLY cycle -> actionEnable=0 on the next cycle, all outputs at reset values, turnCount=0.
